// File: rtl/dlsc_pcie_pkg.sv
// dlsc_pcie_pkg: shared PCIe TLP fmt/type codes and inbound decoder state encoding
package dlsc_pcie_pkg;
  localparam logic [1:0] FMT_3DW_ND = 2'b00;
  localparam logic [1:0] FMT_4DW_ND = 2'b01;
  localparam logic [1:0] FMT_3DW_D  = 2'b10;
  localparam logic [1:0] FMT_4DW_D  = 2'b11;
  localparam logic [4:0] TYPE_MEM   = 5'b00000;
  localparam logic [4:0] TYPE_IO    = 5'b00010;
  typedef enum logic [2:0] {ST_H0, ST_H1, ST_H2, ST_H3, ST_CMD, ST_DATA, ST_DROP} state_t;
  function automatic logic fmt_4dw(input logic [1:0] fmt);
    return fmt == FMT_4DW_ND || fmt == FMT_4DW_D;
  endfunction
  function automatic logic fmt_data(input logic [1:0] fmt);
    return fmt == FMT_3DW_D || fmt == FMT_4DW_D;
  endfunction
endpackage

// File: rtl/dlsc_pcie_s6_inbound_strb.sv
// dlsc_pcie_s6_inbound_strb: write-data DW counter, byte strobes and last-beat flag
module dlsc_pcie_s6_inbound_strb (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_beat,
  input  logic [9:0] i_len,
  input  logic [3:0] i_be_first,
  input  logic [3:0] i_be_last,
  output logic [3:0] o_strb,
  output logic       o_last
);
  logic [9:0] r_cnt;
  logic       r_first;
  // len 0 wraps to 1023 remaining beats, i.e. a 1024-DW payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else if (i_load) begin
      r_cnt   <= i_len - 10'd1;
      r_first <= 1'b1;
    end else if (i_beat) begin
      r_cnt   <= r_cnt - 10'd1;
      r_first <= 1'b0;
    end
  end
  assign o_last = r_cnt == 10'd0;
  assign o_strb = r_first ? i_be_first : (o_last ? i_be_last : 4'hF);
endmodule

// File: rtl/dlsc_pcie_s6_inbound_decode.sv
// dlsc_pcie_s6_inbound_decode: splits inbound PCIe request TLPs into AXI read/write
// commands and write data, and queues completion IDs for non-posted requests.
module dlsc_pcie_s6_inbound_decode
  import dlsc_pcie_pkg::*;
#(
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rx_ready,
  input  logic            rx_valid,
  input  logic [31:0]     rx_data,
  input  logic            rx_last,
  input  logic            tlp_id_ready,
  output logic            tlp_id_valid,
  output logic            tlp_id_write,
  output logic [28:0]     tlp_id_data,
  input  logic            rd_cmd_ready,
  output logic            rd_cmd_valid,
  output logic [ADDR-1:0] rd_cmd_addr,
  output logic [9:0]      rd_cmd_len,
  output logic [3:0]      rd_cmd_be_first,
  output logic [3:0]      rd_cmd_be_last,
  input  logic            wr_cmd_ready,
  output logic            wr_cmd_valid,
  output logic [ADDR-1:0] wr_cmd_addr,
  output logic [9:0]      wr_cmd_len,
  output logic            wr_cmd_np,
  input  logic            wr_d_ready,
  output logic            wr_d_valid,
  output logic [31:0]     wr_d_data,
  output logic [3:0]      wr_d_strb,
  output logic            wr_d_last,
  output logic            err_unsup,
  output logic            err_poison
);
  state_t          r_state, w_next;
  logic [1:0]      r_fmt, r_attr;
  logic [4:0]      r_type;
  logic [2:0]      r_tc;
  logic            r_ep;
  logic [9:0]      r_len;
  logic [15:0]     r_reqid;
  logic [7:0]      r_tag;
  logic [3:0]      r_be_first, r_be_last;
  logic [31:0]     r_addr_hi;
  logic [ADDR-1:0] r_addr;
  logic            r_cmd_done, r_id_done, r_err_unsup, r_err_poison;
  logic            w_rx_acc, w_hdr_end, w_write, w_np, w_unsup, w_poison;
  logic            w_in_cmd, w_cmd_ok, w_id_ok, w_beat;
  logic [63:0]     w_addr64;
  assign w_write   = fmt_data(r_fmt);
  assign w_np      = !w_write || r_type == TYPE_IO;
  assign w_hdr_end = r_state == ST_H3 || (r_state == ST_H2 && !fmt_4dw(r_fmt));
  assign w_addr64  = {(r_state == ST_H3) ? r_addr_hi : 32'h0, rx_data[31:2], 2'b00};
  // IO space only exists with a 3DW header; address bits beyond ADDR are unreachable
  assign w_unsup   = !(r_type == TYPE_MEM || (r_type == TYPE_IO && !fmt_4dw(r_fmt)))
                     || (w_addr64 >> ADDR) != 64'h0;
  assign w_poison  = w_write && r_ep;
  assign rx_ready  = !rst && ((r_state == ST_DATA) ? wr_d_ready : r_state != ST_CMD);
  assign w_rx_acc  = rx_valid && rx_ready;
  assign w_in_cmd  = !rst && r_state == ST_CMD;
  assign rd_cmd_valid = w_in_cmd && !w_write && !r_cmd_done;
  assign wr_cmd_valid = w_in_cmd && w_write && !r_cmd_done;
  assign tlp_id_valid = w_in_cmd && w_np && !r_id_done;
  assign w_cmd_ok  = r_cmd_done || (rd_cmd_valid && rd_cmd_ready) || (wr_cmd_valid && wr_cmd_ready);
  assign w_id_ok   = !w_np || r_id_done || (tlp_id_valid && tlp_id_ready);
  assign wr_d_valid = !rst && r_state == ST_DATA && rx_valid;
  assign w_beat    = wr_d_valid && wr_d_ready;
  assign wr_d_data = {rx_data[7:0], rx_data[15:8], rx_data[23:16], rx_data[31:24]};
  assign tlp_id_write = w_write;
  assign tlp_id_data  = {r_tc, r_attr, r_reqid, r_tag};
  assign rd_cmd_addr  = r_addr;
  assign rd_cmd_len   = r_len;
  assign rd_cmd_be_first = r_be_first;
  assign rd_cmd_be_last  = r_be_last;
  assign wr_cmd_addr  = r_addr;
  assign wr_cmd_len   = r_len;
  assign wr_cmd_np    = r_type == TYPE_IO;
  assign err_unsup    = r_err_unsup;
  assign err_poison   = r_err_poison;
  // a dropped header that already carries rx_last has nothing left to drain
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_H0:        if (w_rx_acc) w_next = ST_H1;
      ST_H1:        if (w_rx_acc) w_next = ST_H2;
      ST_H2, ST_H3: if (w_rx_acc) w_next = !w_hdr_end ? ST_H3 :
                                          (w_unsup || w_poison) ? (rx_last ? ST_H0 : ST_DROP) : ST_CMD;
      ST_CMD:       if (w_cmd_ok && w_id_ok) w_next = w_write ? ST_DATA : ST_H0;
      ST_DATA:      if (w_beat && wr_d_last) w_next = ST_H0;
      default:      if (w_rx_acc && rx_last) w_next = ST_H0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_H0;
      r_cmd_done   <= 1'b0;
      r_id_done    <= 1'b0;
      r_err_unsup  <= 1'b0;
      r_err_poison <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cmd_done   <= w_in_cmd && w_next == ST_CMD && w_cmd_ok;
      r_id_done    <= w_in_cmd && w_next == ST_CMD && w_id_ok;
      r_err_unsup  <= w_rx_acc && w_hdr_end && w_unsup;
      r_err_poison <= w_rx_acc && w_hdr_end && !w_unsup && w_poison;
    end
  end
  always_ff @(posedge clk) begin
    if (w_rx_acc && r_state == ST_H0) begin
      r_fmt  <= rx_data[30:29];
      r_type <= rx_data[28:24];
      r_tc   <= rx_data[22:20];
      r_ep   <= rx_data[14];
      r_attr <= rx_data[13:12];
      r_len  <= rx_data[9:0];
    end
    if (w_rx_acc && r_state == ST_H1) begin
      r_reqid    <= rx_data[31:16];
      r_tag      <= rx_data[15:8];
      r_be_last  <= rx_data[7:4];
      r_be_first <= rx_data[3:0];
    end
    if (w_rx_acc && r_state == ST_H2) r_addr_hi <= rx_data;
    if (w_rx_acc && w_hdr_end) r_addr <= w_addr64[ADDR-1:0];
  end
  dlsc_pcie_s6_inbound_strb u_strb (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_CMD),
    .i_beat     (w_beat),
    .i_len      (r_len),
    .i_be_first (r_be_first),
    .i_be_last  (r_be_last),
    .o_strb     (wr_d_strb),
    .o_last     (wr_d_last)
  );
endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_decode.sv
// tb_dlsc_pcie_s6_inbound_decode: directed TLPs with a queue scoreboard on every output channel
module tb_dlsc_pcie_s6_inbound_decode;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rx_ready, rx_valid, rx_last;
  logic [31:0] rx_data;
  logic        tlp_id_ready, tlp_id_valid, tlp_id_write;
  logic [28:0] tlp_id_data;
  logic        rd_cmd_ready, rd_cmd_valid;
  logic [31:0] rd_cmd_addr;
  logic [9:0]  rd_cmd_len;
  logic [3:0]  rd_cmd_be_first, rd_cmd_be_last;
  logic        wr_cmd_ready, wr_cmd_valid, wr_cmd_np;
  logic [31:0] wr_cmd_addr;
  logic [9:0]  wr_cmd_len;
  logic        wr_d_ready, wr_d_valid, wr_d_last;
  logic [31:0] wr_d_data;
  logic [3:0]  wr_d_strb;
  logic        err_unsup, err_poison;
  int errors = 0, checks = 0;
  logic [49:0] q_rd[$];
  logic [42:0] q_wr[$];
  logic [36:0] q_d[$];
  logic [29:0] q_id[$];
  logic [1:0]  q_err[$];
  dlsc_pcie_s6_inbound_decode #(.ADDR(32)) dut (
    .clk(clk), .rst(rst),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .tlp_id_ready(tlp_id_ready), .tlp_id_valid(tlp_id_valid), .tlp_id_write(tlp_id_write), .tlp_id_data(tlp_id_data),
    .rd_cmd_ready(rd_cmd_ready), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_cmd_be_first(rd_cmd_be_first), .rd_cmd_be_last(rd_cmd_be_last),
    .wr_cmd_ready(wr_cmd_ready), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_cmd_np(wr_cmd_np),
    .wr_d_ready(wr_d_ready), .wr_d_valid(wr_d_valid), .wr_d_data(wr_d_data), .wr_d_strb(wr_d_strb), .wr_d_last(wr_d_last),
    .err_unsup(err_unsup), .err_poison(err_poison)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected output %h, expected none", name, act);
  endtask
  always @(negedge clk) begin
    if (rd_cmd_valid && rd_cmd_ready) begin
      if (q_rd.size() == 0) unexpected("rd_cmd", {rd_cmd_addr, rd_cmd_len, rd_cmd_be_first, rd_cmd_be_last});
      else chk("rd_cmd", {rd_cmd_addr, rd_cmd_len, rd_cmd_be_first, rd_cmd_be_last}, q_rd.pop_front());
    end
    if (wr_cmd_valid && wr_cmd_ready) begin
      if (q_wr.size() == 0) unexpected("wr_cmd", {wr_cmd_addr, wr_cmd_len, wr_cmd_np});
      else chk("wr_cmd", {wr_cmd_addr, wr_cmd_len, wr_cmd_np}, q_wr.pop_front());
    end
    if (wr_d_valid && wr_d_ready) begin
      if (q_d.size() == 0) unexpected("wr_d", {wr_d_data, wr_d_strb, wr_d_last});
      else chk("wr_d", {wr_d_data, wr_d_strb, wr_d_last}, q_d.pop_front());
    end
    if (tlp_id_valid && tlp_id_ready) begin
      if (q_id.size() == 0) unexpected("tlp_id", {tlp_id_write, tlp_id_data});
      else chk("tlp_id", {tlp_id_write, tlp_id_data}, q_id.pop_front());
    end
    if (err_unsup || err_poison) begin
      if (q_err.size() == 0) unexpected("err", {err_poison, err_unsup});
      else chk("err", {err_poison, err_unsup}, q_err.pop_front());
    end
  end
  task automatic send(input logic [31:0] d, input logic l);
    bit acc = 1'b0;
    rx_valid = 1'b1; rx_data = d; rx_last = l;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
    end
    #1 rx_valid = 1'b0; rx_last = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send: dw %h not accepted, rx_ready stayed 0 for 100 cycles", d);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rx_valid = 0; rx_data = 0; rx_last = 0;
    rd_cmd_ready = 1; wr_cmd_ready = 1; wr_d_ready = 1; tlp_id_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rx_ready", rx_ready, 0);
    chk("reset valids", {rd_cmd_valid, wr_cmd_valid, wr_d_valid, tlp_id_valid, err_unsup, err_poison}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle rx_ready", rx_ready, 1);
    @(posedge clk); #1;
    // 3DW MRd
    q_rd.push_back({32'h0000_1000, 10'd4, 4'h0, 4'hF});
    q_id.push_back({1'b0, 3'd0, 2'd0, 16'h1234, 8'h56});
    send(32'h0000_0004, 0); send(32'h1234_56F0, 0); send(32'h0000_1000, 1);
    @(negedge clk);
    chk("mrd3 latency", {rd_cmd_valid, tlp_id_valid}, 2'b11);
    @(posedge clk); #1;
    // 3DW MWr len 3
    q_wr.push_back({32'h0000_2004, 10'd3, 1'b0});
    q_d.push_back({32'h4433_2211, 4'hC, 1'b0});
    q_d.push_back({32'h4433_2211, 4'hF, 1'b0});
    q_d.push_back({32'h4433_2211, 4'h3, 1'b1});
    send(32'h4000_0003, 0); send(32'hABCD_013C, 0); send(32'h0000_2004, 0);
    for (int i = 0; i < 3; i++) send(32'h1122_3344, i == 2);
    // IOWr len 1 with completion ID held off
    tlp_id_ready = 0;
    q_wr.push_back({32'h0000_0040, 10'd1, 1'b1});
    q_id.push_back({1'b1, 3'd5, 2'd2, 16'hBEEF, 8'h7A});
    q_d.push_back({32'hDDCC_BBAA, 4'hF, 1'b1});
    send(32'h4250_2001, 0); send(32'hBEEF_7A0F, 0); send(32'h0000_0040, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("id stall rx_ready", rx_ready, 0);
      chk("id stall id", {tlp_id_valid, tlp_id_write, tlp_id_data}, {2'b11, 3'd5, 2'd2, 16'hBEEF, 8'h7A});
    end
    @(posedge clk); #1 tlp_id_ready = 1;
    send(32'hAABB_CCDD, 1);
    // MRdLk is unsupported; header carries rx_last
    q_err.push_back(2'b01);
    send(32'h0100_0001, 0); send(32'h0000_000F, 0); send(32'h0000_0010, 1);
    // 4DW MRd with upper address nonzero, then zero
    q_err.push_back(2'b01);
    send(32'h2000_0001, 0); send(32'h0001_020F, 0); send(32'h0000_0001, 0); send(32'h0000_3000, 1);
    q_rd.push_back({32'h0000_3000, 10'd1, 4'hF, 4'h0});
    q_id.push_back({1'b0, 3'd0, 2'd0, 16'h0001, 8'h02});
    send(32'h2000_0001, 0); send(32'h0001_020F, 0); send(32'h0000_0000, 0); send(32'h0000_3000, 1);
    @(negedge clk);
    chk("mrd4 latency", {rd_cmd_valid, tlp_id_valid}, 2'b11);
    @(posedge clk); #1;
    // poisoned MWr len 1024, then MRd behind it
    q_err.push_back(2'b10);
    send(32'h4000_4000, 0); send(32'h0000_00FF, 0); send(32'h0000_0100, 0);
    for (int i = 0; i < 1024; i++) send(i, i == 1023);
    q_rd.push_back({32'h0000_ABC8, 10'd2, 4'hF, 4'hF});
    q_id.push_back({1'b0, 3'd0, 2'd0, 16'h5555, 8'hAA});
    send(32'h0000_0002, 0); send(32'h5555_AAFF, 0); send(32'h0000_ABC8, 1);
    // reset two beats into an 8-beat write
    q_wr.push_back({32'h0000_0500, 10'd8, 1'b0});
    q_d.push_back({32'h0403_0201, 4'hF, 1'b0});
    q_d.push_back({32'h0807_0605, 4'hF, 1'b0});
    send(32'h4000_0008, 0); send(32'h0000_00FF, 0); send(32'h0000_0500, 0);
    send(32'h0102_0304, 0); send(32'h0506_0708, 0);
    rst = 1;
    @(negedge clk);
    chk("midrst valids", {rx_ready, rd_cmd_valid, wr_cmd_valid, wr_d_valid, tlp_id_valid}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post-rst rx_ready", rx_ready, 1);
    @(posedge clk); #1;
    q_rd.push_back({32'h0000_0800, 10'd1, 4'hF, 4'h0});
    q_id.push_back({1'b0, 3'd0, 2'd0, 16'h0BAD, 8'h11});
    send(32'h0000_0001, 0); send(32'h0BAD_110F, 0); send(32'h0000_0800, 1);
    repeat (5) @(negedge clk);
    chk("rd drained", q_rd.size(), 0);
    chk("wr drained", q_wr.size(), 0);
    chk("wr_d drained", q_d.size(), 0);
    chk("id drained", q_id.size(), 0);
    chk("err drained", q_err.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
